// File: rtl/nrzi_stuff_tx.sv
// USB transmit line encoder: bit stuffing, NRZI, EOP generation.
// Registered line outputs show the action taken in the previous cycle.
module nrzi_stuff_tx (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_in_valid,
  input  logic pkt_end,
  output logic bit_in_ready,
  output logic dp,
  output logic dm,
  output logic oe,
  output logic tx_done,
  output logic tx_err
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    STUFF,
    SE0A,
    SE0B,
    EOPJ
  } state_t;

  state_t     state;
  state_t     state_n;
  logic       lvl;
  logic       lvl_n;
  logic [2:0] ones_cnt;
  logic [2:0] ones_cnt_n;
  logic       eop_pend;
  logic       eop_pend_n;
  logic       dp_n;
  logic       dm_n;
  logic       oe_n;
  logic       done_n;
  logic       err_n;

  assign bit_in_ready = (state == IDLE) || (state == DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lvl      <= 1'b1;
      ones_cnt <= 3'd0;
      eop_pend <= 1'b0;
      dp       <= 1'b1;
      dm       <= 1'b0;
      oe       <= 1'b0;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      state    <= state_n;
      lvl      <= lvl_n;
      ones_cnt <= ones_cnt_n;
      eop_pend <= eop_pend_n;
      dp       <= dp_n;
      dm       <= dm_n;
      oe       <= oe_n;
      tx_done  <= done_n;
      tx_err   <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    lvl_n      = lvl;
    ones_cnt_n = ones_cnt;
    eop_pend_n = eop_pend;
    dp_n       = lvl;
    dm_n       = ~lvl;
    oe_n       = 1'b1;
    done_n     = 1'b0;
    err_n      = 1'b0;
    unique case (state)
      IDLE, DATA: begin
        if (bit_in_valid) begin
          // NRZI: a 0 toggles the line, a 1 holds it
          lvl_n      = bit_in ? lvl : ~lvl;
          ones_cnt_n = bit_in ? ones_cnt + 3'd1 : 3'd0;
          dp_n       = lvl_n;
          dm_n       = ~lvl_n;
          if (ones_cnt_n == 3'd6) begin
            state_n    = STUFF;
            eop_pend_n = pkt_end;
          end else if (pkt_end) begin
            state_n = SE0A;
          end else begin
            state_n = DATA;
          end
        end else if (state == IDLE) begin
          dp_n = 1'b1;
          dm_n = 1'b0;
          oe_n = 1'b0;
        end else if (pkt_end) begin
          // last bit already sent: this cycle is the first SE0
          state_n = SE0B;
          dp_n    = 1'b0;
          dm_n    = 1'b0;
        end else begin
          err_n = 1'b1;
        end
      end
      STUFF: begin
        lvl_n      = ~lvl;
        ones_cnt_n = 3'd0;
        dp_n       = ~lvl;
        dm_n       = lvl;
        eop_pend_n = 1'b0;
        state_n    = eop_pend ? SE0A : DATA;
      end
      SE0A: begin
        dp_n    = 1'b0;
        dm_n    = 1'b0;
        state_n = SE0B;
      end
      SE0B: begin
        dp_n    = 1'b0;
        dm_n    = 1'b0;
        state_n = EOPJ;
      end
      EOPJ: begin
        dp_n       = 1'b1;
        dm_n       = 1'b0;
        done_n     = 1'b1;
        lvl_n      = 1'b1;
        ones_cnt_n = 3'd0;
        state_n    = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nrzi_stuff_tx.sv
// Directed bench for nrzi_stuff_tx.
// Each vector packs {dp,dm,oe,ready,done,err}.
module tb_nrzi_stuff_tx;

  logic clk = 1'b0;
  logic rst;
  logic bit_in;
  logic bit_in_valid;
  logic pkt_end;
  logic bit_in_ready;
  logic dp;
  logic dm;
  logic oe;
  logic tx_done;
  logic tx_err;

  int n_vec = 0;
  int n_bad = 0;

  nrzi_stuff_tx dut (
    .clk          (clk),
    .rst          (rst),
    .bit_in       (bit_in),
    .bit_in_valid (bit_in_valid),
    .pkt_end      (pkt_end),
    .bit_in_ready (bit_in_ready),
    .dp           (dp),
    .dm           (dm),
    .oe           (oe),
    .tx_done      (tx_done),
    .tx_err       (tx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [5:0] got,
                     input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] obs();
    return {dp, dm, oe, bit_in_ready, tx_done, tx_err};
  endfunction

  task automatic cyc(input string tag, input logic v,
                     input logic b, input logic e,
                     input logic [5:0] exp);
    bit_in_valid = v;
    bit_in       = b;
    pkt_end      = e;
    @(posedge clk);
    #1;
    chk(tag, obs(), exp);
  endtask

  localparam logic [5:0] IDL = 6'b100100;
  localparam logic [5:0] SE0 = 6'b001000;
  localparam logic [5:0] JDN = 6'b101110;
  localparam logic [5:0] JR  = 6'b101100;
  localparam logic [5:0] KR  = 6'b011100;
  localparam logic [5:0] JB  = 6'b101000;
  localparam logic [5:0] KB  = 6'b011000;
  localparam logic [5:0] JE  = 6'b101101;

  initial begin
    rst = 1'b1;
    bit_in = 1'b0;
    bit_in_valid = 1'b0;
    pkt_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", obs(), IDL);
    rst = 1'b0;

    cyc("idle_pkt_end", 1'b0, 1'b0, 1'b1, IDL);

    // 0,0,1,0 then 1 with pkt_end
    cyc("nrzi0", 1'b1, 1'b0, 1'b0, KR);
    cyc("nrzi1", 1'b1, 1'b0, 1'b0, JR);
    cyc("nrzi2", 1'b1, 1'b1, 1'b0, JR);
    cyc("nrzi3", 1'b1, 1'b0, 1'b0, KR);
    cyc("last",  1'b1, 1'b1, 1'b1, KB);
    cyc("se0a",  1'b0, 1'b0, 1'b0, SE0);
    cyc("se0b",  1'b0, 1'b0, 1'b0, SE0);
    cyc("eopj",  1'b0, 1'b0, 1'b0, JDN);
    cyc("idle1", 1'b0, 1'b0, 1'b0, IDL);

    // 0 then seven 1s
    cyc("s_zero", 1'b1, 1'b0, 1'b0, KR);
    for (int i = 0; i < 5; i++)
      cyc("s_ones", 1'b1, 1'b1, 1'b0, KR);
    cyc("s_sixth", 1'b1, 1'b1, 1'b0, KB);
    cyc("s_stuff", 1'b1, 1'b1, 1'b0, JR);
    cyc("s_seventh", 1'b1, 1'b1, 1'b0, JR);
    cyc("s_last", 1'b1, 1'b0, 1'b1, KB);
    cyc("s_se0a", 1'b0, 1'b0, 1'b0, SE0);
    cyc("s_se0b", 1'b0, 1'b0, 1'b0, SE0);
    cyc("s_eopj", 1'b0, 1'b0, 1'b0, JDN);
    cyc("s_idle", 1'b0, 1'b0, 1'b0, IDL);

    // six 1s, sixth carries pkt_end
    for (int i = 0; i < 5; i++)
      cyc("e_ones", 1'b1, 1'b1, 1'b0, JR);
    cyc("e_sixth", 1'b1, 1'b1, 1'b1, JB);
    cyc("e_stuff", 1'b0, 1'b0, 1'b0, KB);
    cyc("e_se0a", 1'b0, 1'b0, 1'b0, SE0);
    cyc("e_se0b", 1'b0, 1'b0, 1'b0, SE0);
    cyc("e_eopj", 1'b0, 1'b0, 1'b0, JDN);
    cyc("e_idle", 1'b0, 1'b0, 1'b0, IDL);

    // underrun gap keeps the ones count
    cyc("u_one", 1'b1, 1'b1, 1'b0, JR);
    cyc("u_one", 1'b1, 1'b1, 1'b0, JR);
    cyc("u_gap0", 1'b0, 1'b0, 1'b0, JE);
    cyc("u_gap1", 1'b0, 1'b0, 1'b0, JE);
    for (int i = 0; i < 3; i++)
      cyc("u_ones", 1'b1, 1'b1, 1'b0, JR);
    cyc("u_sixth", 1'b1, 1'b1, 1'b0, JB);
    cyc("u_stuff", 1'b1, 1'b0, 1'b1, KR);
    cyc("u_last", 1'b1, 1'b0, 1'b1, JB);
    cyc("u_se0a", 1'b0, 1'b0, 1'b0, SE0);
    cyc("u_se0b", 1'b0, 1'b0, 1'b0, SE0);
    cyc("u_eopj", 1'b0, 1'b0, 1'b0, JDN);
    cyc("u_idle", 1'b0, 1'b0, 1'b0, IDL);

    // reset while in SE0A
    cyc("r_last", 1'b1, 1'b0, 1'b1, KB);
    bit_in_valid = 1'b0;
    pkt_end = 1'b0;
    rst = 1'b1;
    #1;
    chk("r_async", obs(), IDL);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("r_hold", obs(), IDL);
    end
    rst = 1'b0;
    cyc("r_idle", 1'b0, 1'b0, 1'b0, IDL);
    cyc("r_resume", 1'b1, 1'b0, 1'b0, KR);
    cyc("r_gap", 1'b0, 1'b0, 1'b0, 6'b011101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
